// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg
// Shared types and helpers for the shared-register round-robin arbiter.
//   state_t    : controller state (IDLE accepts a write, LOCK holds the value)
//   MAX_REQ    : widest requester vector the onehot helper can describe
//   idx_width  : width of a requester index for a given requester count
//   onehot     : one-hot mask with bit idx set, limited to n requesters
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int MAX_REQ = 32;

  // Every instance derives its own index width from its requester count.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits at or above n are never set, so callers can truncate freely.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] mask;
    mask = '0;
    if (idx >= 0 && idx < n && idx < MAX_REQ) begin
      mask[idx] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector.
//   req     : request vector, bit i belongs to requester i
//   ptr     : requester that has top priority this round
//   winner  : first set request at or above ptr, wrapping N_REQ-1 -> 0
//   any_req : at least one request bit is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Walk the requesters in priority order starting at ptr; the first hit wins
  // and any_req doubles as the "already found" flag so later hits are ignored.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!any_req && req[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Write controller and owner tracker for one WIDTH-bit register shared by
// N_REQ requesters. A granted requester's word is stored, then the register
// is locked for HOLD cycles so downstream logic sees a stable value.
//   clk     : clock, all state changes on its rising edge
//   rst     : asynchronous active-low reset
//   req     : per-requester write request
//   data    : write data, requester i drives data[i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant pulse, one cycle per write
//   q       : shared register contents
//   q_valid : sticky flag, set by the first write
//   owner   : index of the most recent writer
//   busy    : high during the lock period after a write
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             do_write;
  logic [N_REQ-1:0] gnt_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state logic. A write only happens from IDLE; with HOLD=0 the
  // controller never leaves IDLE so a grant is possible every cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          do_write = 1'b1;
          if (HOLD > 0) begin
            state_d = LOCK;
            cnt_d   = CNT_INIT;
          end
        end
      end
      LOCK: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Priority moves to the requester just after the winner, wrapping to 0.
  always_comb begin
    next_ptr = '0;
    if (int'(winner) != N_REQ - 1) begin
      next_ptr = winner + IDX_W'(1);
    end
    gnt_next = N_REQ'(onehot(int'(winner), N_REQ));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage, owner and round-robin pointer only change on a write; the grant
  // pulse is cleared on every other edge so it lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      gnt     <= '0;
      ptr_q   <= '0;
    end else begin
      gnt <= do_write ? gnt_next : '0;
      if (do_write) begin
        q       <= data[int'(winner)*WIDTH +: WIDTH];
        q_valid <= 1'b1;
        owner   <= winner;
        ptr_q   <= next_ptr;
      end
    end
  end

  assign busy = (state_q == LOCK);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
// Directed bench for shared_reg_arbiter. A HOLD=2 instance runs a per-cycle
// vector table (fairness, single write, lock masking, wrap-around) plus
// hand-written reset sequences; a HOLD=0 instance checks back-to-back grants.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        busy;

  logic [3:0]  req2;
  logic [31:0] data2;
  logic [3:0]  gnt2;
  logic [7:0]  q2;
  logic        q_valid2;
  logic [1:0]  owner2;
  logic        busy2;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D0 = 32'h3322_1100;
  localparam logic [31:0] D1 = 32'h3322_A500;

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(0)) dut_h0 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
    .data    (data2),
    .gnt     (gnt2),
    .q       (q2),
    .q_valid (q_valid2),
    .owner   (owner2),
    .busy    (busy2)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    req  = r;
    data = d;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                             input logic [1:0] e_owner, input logic e_valid, input logic e_busy);
    checkVal({tag, " gnt"},     32'(gnt),     32'(e_gnt));
    checkVal({tag, " q"},       32'(q),       32'(e_q));
    checkVal({tag, " owner"},   32'(owner),   32'(e_owner));
    checkVal({tag, " q_valid"}, 32'(q_valid), 32'(e_valid));
    checkVal({tag, " busy"},    32'(busy),    32'(e_busy));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    req2  = '0;
    data2 = '0;
    applyStimulus(4'b0000, D0);

    // req, data, gnt, q, owner, q_valid, busy after the edge
    // fairness with everyone requesting: grants 0,1,2,3,0 every 3 cycles
    vecs.push_back('{4'hF, D0, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'hF, D0, 4'b0010, 8'h11, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h11, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h11, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'hF, D0, 4'b0100, 8'h22, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h22, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h22, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'hF, D0, 4'b1000, 8'h33, 2'd3, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{4'hF, D0, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'hF, D0, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'h0, D1, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b0});
    // single write from requester 1, then requests during LOCK are ignored
    vecs.push_back('{4'h2, D1, 4'b0010, 8'hA5, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{4'h4, D1, 4'b0000, 8'hA5, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{4'h4, D1, 4'b0000, 8'hA5, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'h4, D1, 4'b0100, 8'h22, 2'd2, 1'b1, 1'b1});
    // wrap-around: pointer at 3, req=1001 gives 3 then 0
    vecs.push_back('{4'h9, D1, 4'b0000, 8'h22, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{4'h9, D1, 4'b0000, 8'h22, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'h9, D1, 4'b1000, 8'h33, 2'd3, 1'b1, 1'b1});
    vecs.push_back('{4'h9, D1, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b1});
    vecs.push_back('{4'h9, D1, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{4'h9, D1, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'h0, D1, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{4'h0, D1, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'h0, D1, 4'b0000, 8'h00, 2'd0, 1'b1, 1'b0});

    // reset state held across a couple of edges
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].data);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].owner,
                  vecs[i].valid, vecs[i].busy);
      @(negedge clk);
    end

    // pointer now 1: grant requester 2, then reset asynchronously mid-LOCK
    applyStimulus(4'b0100, D0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_grant", 4'b0100, 8'h22, 2'd2, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    applyStimulus(4'hF, D0);
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_after_reset", 4'b0001, 8'h00, 2'd0, 1'b1, 1'b1);

    // second mid-LOCK reset, then only requester 3 asks
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset2", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1000, D0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("req3_after_reset", 4'b1000, 8'h33, 2'd3, 1'b1, 1'b1);

    // HOLD=0 instance: two requesters alternate every cycle, never busy
    @(negedge clk);
    req2  = 4'b0011;
    data2 = 32'h4433_2211;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("h0_gnt%0d", i),  32'(gnt2),  (i % 2 == 0) ? 32'h1 : 32'h2);
      checkVal($sformatf("h0_q%0d", i),    32'(q2),    (i % 2 == 0) ? 32'h11 : 32'h22);
      checkVal($sformatf("h0_busy%0d", i), 32'(busy2), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among N_REQ requesters.
- Each granted requester writes its data word into the shared register.
- After each write, a lock period of HOLD cycles blocks further writes so the stored value is stable for downstream logic.
- Sits in front of the shared storage register as its write controller and owner tracker.

Parameters:
- N_REQ, 4, number of requesters; minimum 2, need not be a power of two.
- WIDTH, 8, width of the shared register and of each data word.
- HOLD, 2, lock cycles after each write; minimum 0.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  N_REQ  per-requester write request; bit i belongs to requester i.
- data  input  N_REQ*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant pulse, registered.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high once any write has occurred.
- owner  output  $clog2(N_REQ)  index of the last writer.
- busy  output  1  high while in the lock period.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately in any state):
  - q=0, q_valid=0, gnt=0, owner=0, busy=0.
  - Round-robin pointer=0; state=IDLE; hold counter=0.
- Reset release: the first arbitration can occur on the first rising edge with rst high.
- States: IDLE, LOCK.
- IDLE, no req bit set: everything holds; gnt=0.
- IDLE, any req bit set, on the rising edge:
  - Winner w is the first set req bit at or above the pointer, searching upward with wrap N_REQ-1 -> 0.
  - q <= data slice w; gnt <= onehot(w) for exactly one cycle; owner <= w; q_valid <= 1.
  - pointer <= (w+1) mod N_REQ.
  - If HOLD>0: state <= LOCK, counter <= HOLD-1, busy <= 1.
  - If HOLD=0: remain in IDLE, so a new grant is possible every cycle.
- Latency: a request sampled at edge k is granted and written at edge k; gnt and q are visible in the cycle after edge k.
- LOCK:
  - No grants; gnt=0; req and data ignored; q holds.
  - Counter decrements each edge. When counter=0, the next edge returns to IDLE with busy <= 0.
  - Result: exactly HOLD cycles with busy=1 between grants, giving a minimum grant spacing of HOLD+1 cycles.
- Requester protocol:
  - Requester holds req and data stable until it sees its gnt bit.
  - It drops req in the gnt cycle if it has no further write.
  - A req still high after gnt is treated as a new request and competes with rotated priority.
- Fairness: with all requesters continuously requesting, each is granted once per N_REQ grants. No requester waits more than N_REQ-1 other grants.
- q_valid is sticky: it clears only on reset.
- Non-requesting bits never influence the winner, so data slices of idle requesters are don't-care.

Decomposition:
- Package shared_reg_arbiter_pkg holds:
  - state enum {IDLE, LOCK};
  - function onehot(idx, n);
  - localparam IDX_W = $clog2(N_REQ), computed per instance.
- One combinational sub-module, rr_pick (inputs req and pointer; outputs winner index and any_req). It is instantiated once.
- The storage register, owner register and hold counter live in the top module.

Test Plan:
1. Reset: drive rst=0 mid-simulation with req=1111 → q=0, gnt=0, busy=0, q_valid=0, owner=0 immediately, with no edge needed. Release; the first grant goes to requester 0.
2. Single write (N_REQ=4, WIDTH=8, HOLD=2): req=0010, data[1]=0xA5 at edge k → after edge k: gnt=0010 for one cycle, q=0xA5, owner=1, q_valid=1, busy=1 for 2 cycles. The next grant is possible at edge k+3; pointer=2.
3. Fairness: req=1111 held, data[i]=0x11*i → grants 0,1,2,3,0 at edges k, k+3, k+6, k+9, k+12; q steps 0x00,0x11,0x22,0x33,0x00.
4. Wrap-around: after a grant to requester 2 (pointer=3), req=1001 → grants 3 then 0; owner goes 3 then 0.
5. Reset mid-LOCK: assert rst low one cycle after a grant → busy, q and pointer clear at once. After release, req=1000 → gnt=1000 on the first edge.
6. HOLD=0 build: req=0011 held → gnt alternates 0001, 0010 every cycle; busy stays 0.
